// File: rtl/adc_input_conditioner.sv
// adc_input_conditioner: ADC overrange saturation with optional stretch, test-pattern injection,
// overrange event counting and NCO bus alignment delay ahead of the DDC mixer.
module adc_input_conditioner #(
  parameter int ADBITWIDTH  = 16,
  parameter int NCOBITWIDTH = 25,
  parameter int HOLD_W      = 8,
  parameter int CNT_W       = 16,
  parameter int NCO_DLY     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   orp,
  input  logic [ADBITWIDTH-1:0]  dataa_in,
  input  logic [NCOBITWIDTH-1:0] datab_in,
  input  logic [NCOBITWIDTH-1:0] datac_in,
  input  logic [ADBITWIDTH-1:0]  sin_val,
  input  logic [1:0]             mode,
  input  logic [ADBITWIDTH-1:0]  const_val,
  input  logic [HOLD_W-1:0]      hold_len,
  input  logic                   ovr_cnt_clr,
  output logic [ADBITWIDTH-1:0]  dataa_out,
  output logic [NCOBITWIDTH-1:0] datab_out,
  output logic [NCOBITWIDTH-1:0] datac_out,
  output logic                   ovr_flag,
  output logic [CNT_W-1:0]       ovr_cnt
);
  typedef enum logic [1:0] {IDLE, SAT, HOLD} state_e;
  state_e                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   orp_q;
  logic                   flag_q, sat;
  logic [ADBITWIDTH-1:0]  ramp_q, dataa_q, dataa_d, sat_val;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NCOBITWIDTH-1:0] b_q [NCO_DLY];
  logic [NCOBITWIDTH-1:0] c_q [NCO_DLY];
  // orp always wins: it (re)enters SAT from any state and refreshes the saturation sign
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    hold_d  = hold_q;
    if (orp) begin
      state_d = SAT;
      sign_d  = dataa_in[ADBITWIDTH-1];
    end else if (state_q == SAT) begin
      state_d = (hold_len == '0) ? IDLE : HOLD;
      hold_d  = hold_len;
    end else if (state_q == HOLD) begin
      state_d = (hold_q == HOLD_W'(1)) ? IDLE : HOLD;
      hold_d  = hold_q - 1'b1;
    end
  end
  assign sat     = (state_d != IDLE);
  assign sat_val = sign_d ? {1'b1, {(ADBITWIDTH-1){1'b0}}} : {1'b0, {(ADBITWIDTH-1){1'b1}}};
  assign dataa_d = (mode == 2'b10) ? ramp_q :
                   (mode == 2'b11) ? const_val :
                   sat             ? sat_val :
                   mode[0]         ? sin_val : dataa_in;
  assign cnt_d   = ovr_cnt_clr ? '0 :
                   (orp & ~orp_q & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      hold_q  <= '0;
      orp_q   <= 1'b0;
      flag_q  <= 1'b0;
      ramp_q  <= '0;
      dataa_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NCO_DLY; i++) begin
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      hold_q  <= hold_d;
      orp_q   <= orp;
      flag_q  <= sat;
      ramp_q  <= (mode == 2'b10) ? ramp_q + 1'b1 : '0;
      dataa_q <= dataa_d;
      cnt_q   <= cnt_d;
      b_q[0]  <= datab_in;
      c_q[0]  <= datac_in;
      for (int i = 1; i < NCO_DLY; i++) begin
        b_q[i] <= b_q[i-1];
        c_q[i] <= c_q[i-1];
      end
    end
  end
  assign dataa_out = dataa_q;
  assign datab_out = b_q[NCO_DLY-1];
  assign datac_out = c_q[NCO_DLY-1];
  assign ovr_flag  = flag_q;
  assign ovr_cnt   = cnt_q;
endmodule

// File: tb/tb_adc_input_conditioner.sv
// tb_adc_input_conditioner: randomized and directed checks of adc_input_conditioner against
// a cycle-level behavioural model (stretch budget, queue-based NCO delay, saturating counter).
module tb_adc_input_conditioner;
  localparam int NCO = 3;
  localparam int CW  = 4;
  logic        clk = 1'b0, rst = 1'b0, orp = 1'b0, ovr_cnt_clr = 1'b0;
  logic [15:0] dataa_in = '0, sin_val = '0, const_val = '0, dataa_out;
  logic [24:0] datab_in = '0, datac_in = '0, datab_out, datac_out;
  logic [1:0]  mode = '0;
  logic [7:0]  hold_len = '0;
  logic        ovr_flag;
  logic [CW-1:0] ovr_cnt;
  int n_vec = 0, n_err = 0;
  bit          m_prev, m_sign;
  int          m_rem, m_cnt;
  logic [15:0] m_ramp, exp_a;
  logic [24:0] qb[$], qc[$], exp_b, exp_c;
  logic        exp_f;
  logic [CW-1:0] exp_cnt;

  adc_input_conditioner #(.NCO_DLY(NCO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .orp(orp), .dataa_in(dataa_in), .datab_in(datab_in),
    .datac_in(datac_in), .sin_val(sin_val), .mode(mode), .const_val(const_val),
    .hold_len(hold_len), .ovr_cnt_clr(ovr_cnt_clr), .dataa_out(dataa_out),
    .datab_out(datab_out), .datac_out(datac_out), .ovr_flag(ovr_flag), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_prev = 0; m_sign = 0; m_rem = 0; m_cnt = 0; m_ramp = '0;
    qb.delete(); qc.delete();
    exp_a = '0; exp_b = '0; exp_c = '0; exp_f = 0; exp_cnt = '0;
  endtask

  // Advance one clock and predict the outputs produced by the inputs sampled at that edge
  task automatic tick();
    bit s;
    @(posedge clk);
    if (ovr_cnt_clr) m_cnt = 0;
    else if (orp && !m_prev && m_cnt < (1 << CW) - 1) m_cnt++;
    if (orp) begin
      s = 1; m_sign = dataa_in[15];
    end else begin
      if (m_prev) m_rem = hold_len;
      s = (m_rem > 0);
      if (s) m_rem--;
    end
    m_prev = orp;
    exp_f = s;
    exp_cnt = m_cnt[CW-1:0];
    exp_a = (mode == 2'b10) ? m_ramp : (mode == 2'b11) ? const_val :
            s ? (m_sign ? 16'h8000 : 16'h7fff) : (mode == 2'b00) ? dataa_in : sin_val;
    m_ramp = (mode == 2'b10) ? m_ramp + 16'd1 : 16'd0;
    qb.push_back(datab_in);
    qc.push_back(datac_in);
    if (qb.size() > NCO) begin
      void'(qb.pop_front());
      void'(qc.pop_front());
    end
    exp_b = (qb.size() == NCO) ? qb[0] : '0;
    exp_c = (qc.size() == NCO) ? qc[0] : '0;
    #1;
  endtask

  task automatic test_reset();
    rst = 0; orp = 1; dataa_in = 16'(urnd()); datab_in = 25'(urnd()); datac_in = 25'(urnd());
    #3;
    model_reset();
    n_vec++; if (dataa_out !== '0) begin n_err++; $display("FAIL reset_dataa: got %h expected 0", dataa_out); end
    n_vec++; if (datab_out !== '0) begin n_err++; $display("FAIL reset_datab: got %h expected 0", datab_out); end
    n_vec++; if (datac_out !== '0) begin n_err++; $display("FAIL reset_datac: got %h expected 0", datac_out); end
    n_vec++; if (ovr_flag !== 1'b0) begin n_err++; $display("FAIL reset_flag: got %b expected 0", ovr_flag); end
    n_vec++; if (ovr_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %h expected 0", ovr_cnt); end
    @(negedge clk); rst = 1;
    tick();
    n_vec++; if (ovr_cnt !== exp_cnt || ovr_cnt !== CW'(1)) begin n_err++; $display("FAIL reset_release_edge: got %h expected %h", ovr_cnt, exp_cnt); end
    n_vec++; if (ovr_flag !== exp_f) begin n_err++; $display("FAIL reset_release_flag: got %b expected %b", ovr_flag, exp_f); end
    orp = 0;
    tick();
  endtask

  function automatic int unsigned urnd();
    return $urandom;
  endfunction

  task automatic test_passthrough();
    logic [15:0] v [2];
    v[0] = 16'h1234; v[1] = 16'h0001;
    mode = 2'b00; orp = 0;
    for (int i = 0; i < 2; i++) begin
      dataa_in = v[i];
      tick();
      n_vec++; if (dataa_out !== exp_a || dataa_out !== v[i]) begin n_err++; $display("FAIL pass_dataa: got %h expected %h", dataa_out, v[i]); end
      n_vec++; if (ovr_flag !== 1'b0) begin n_err++; $display("FAIL pass_flag: got %b expected 0", ovr_flag); end
    end
  endtask

  task automatic test_saturation(input logic [15:0] a, input logic [15:0] satv);
    int nf = 0, ns = 0;
    mode = 2'b00; hold_len = 8'd3; orp = 0; ovr_cnt_clr = 1;
    tick();
    ovr_cnt_clr = 0;
    for (int i = 0; i < 8; i++) begin
      orp = (i < 2);
      dataa_in = (i < 2) ? a : 16'(urnd() & 32'h3fff);
      tick();
      n_vec++; if (dataa_out !== exp_a) begin n_err++; $display("FAIL sat_dataa[%0d]: got %h expected %h", i, dataa_out, exp_a); end
      n_vec++; if (ovr_flag !== exp_f) begin n_err++; $display("FAIL sat_flag[%0d]: got %b expected %b", i, ovr_flag, exp_f); end
      nf += int'(ovr_flag);
      ns += int'(dataa_out === satv);
    end
    n_vec++; if (nf != 5 || ns != 5) begin n_err++; $display("FAIL sat_len: got flag=%0d sat=%0d expected 5", nf, ns); end
    n_vec++; if (ovr_cnt !== CW'(1)) begin n_err++; $display("FAIL sat_cnt: got %h expected 1", ovr_cnt); end
  endtask

  task automatic test_repulse();
    bit p [6];
    p = '{1, 0, 1, 0, 0, 0};
    mode = 2'b01; hold_len = 8'd2; ovr_cnt_clr = 1; orp = 0;
    tick();
    ovr_cnt_clr = 0;
    for (int i = 0; i < 6; i++) begin
      orp = p[i]; dataa_in = 16'h8123; sin_val = 16'(urnd() & 32'h3fff);
      tick();
      n_vec++; if (dataa_out !== exp_a) begin n_err++; $display("FAIL repulse_dataa[%0d]: got %h expected %h", i, dataa_out, exp_a); end
      n_vec++; if (ovr_flag !== (i < 5)) begin n_err++; $display("FAIL repulse_flag[%0d]: got %b expected %b", i, ovr_flag, i < 5); end
    end
    n_vec++; if (dataa_out !== sin_val) begin n_err++; $display("FAIL repulse_sin: got %h expected %h", dataa_out, sin_val); end
    n_vec++; if (ovr_cnt !== CW'(2)) begin n_err++; $display("FAIL repulse_cnt: got %h expected 2", ovr_cnt); end
  endtask

  task automatic test_ramp();
    mode = 2'b10; hold_len = 8'd2; ovr_cnt_clr = 0;
    for (int i = 0; i < 65540; i++) begin
      orp = (urnd() % 64 == 0);
      dataa_in = 16'(urnd());
      tick();
      n_vec++; if (dataa_out !== 16'(i) || dataa_out !== exp_a) begin n_err++; $display("FAIL ramp[%0d]: got %h expected %h", i, dataa_out, 16'(i)); end
      n_vec++; if (ovr_flag !== exp_f || ovr_cnt !== exp_cnt) begin n_err++; $display("FAIL ramp_ovr[%0d]: got %b/%h expected %b/%h", i, ovr_flag, ovr_cnt, exp_f, exp_cnt); end
    end
    orp = 0;
  endtask

  task automatic test_nco();
    mode = 2'b00; orp = 0; datab_in = 25'h1; datac_in = 25'h1;
    for (int i = 0; i < 4; i++) tick();
    datab_in = 25'h1FFFFFF; datac_in = 25'h1FFFFFF;
    for (int k = 1; k <= 5; k++) begin
      dataa_in = 16'(urnd() & 32'h3fff);
      tick();
      n_vec++; if (datab_out !== exp_b || datab_out !== ((k >= NCO) ? 25'h1FFFFFF : 25'h1)) begin n_err++; $display("FAIL nco_b[%0d]: got %h expected %h", k, datab_out, exp_b); end
      n_vec++; if (datac_out !== exp_c || datac_out !== ((k >= NCO) ? 25'h1FFFFFF : 25'h1)) begin n_err++; $display("FAIL nco_c[%0d]: got %h expected %h", k, datac_out, exp_c); end
      n_vec++; if (dataa_out !== dataa_in) begin n_err++; $display("FAIL nco_dataa[%0d]: got %h expected %h", k, dataa_out, dataa_in); end
    end
  endtask

  task automatic test_cnt_sat();
    mode = 2'b00; hold_len = 8'd0; orp = 0; ovr_cnt_clr = 1;
    tick();
    ovr_cnt_clr = 0;
    for (int i = 0; i < 34; i++) begin
      orp = (i % 2 == 0);
      tick();
      n_vec++; if (ovr_cnt !== exp_cnt) begin n_err++; $display("FAIL cnt[%0d]: got %h expected %h", i, ovr_cnt, exp_cnt); end
    end
    n_vec++; if (ovr_cnt !== 4'hF) begin n_err++; $display("FAIL cnt_sat: got %h expected f", ovr_cnt); end
    orp = 1; ovr_cnt_clr = 1;
    tick();
    n_vec++; if (ovr_cnt !== '0 || exp_cnt !== '0) begin n_err++; $display("FAIL cnt_clr_edge: got %h expected 0", ovr_cnt); end
    orp = 0; ovr_cnt_clr = 0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (urnd() % 40 == 0) mode = 2'(urnd());
      orp = (urnd() % 4 == 0);
      ovr_cnt_clr = (urnd() % 32 == 0);
      hold_len = 8'(urnd() % 5);
      dataa_in = 16'(urnd()); sin_val = 16'(urnd()); const_val = 16'(urnd());
      datab_in = 25'(urnd()); datac_in = 25'(urnd());
      tick();
      n_vec++; if (dataa_out !== exp_a) begin n_err++; $display("FAIL rnd_dataa[%0d]: got %h expected %h", i, dataa_out, exp_a); end
      n_vec++; if (ovr_flag !== exp_f) begin n_err++; $display("FAIL rnd_flag[%0d]: got %b expected %b", i, ovr_flag, exp_f); end
      n_vec++; if (ovr_cnt !== exp_cnt) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %h expected %h", i, ovr_cnt, exp_cnt); end
      n_vec++; if (datab_out !== exp_b || datac_out !== exp_c) begin n_err++; $display("FAIL rnd_nco[%0d]: got %h/%h expected %h/%h", i, datab_out, datac_out, exp_b, exp_c); end
    end
    orp = 0; ovr_cnt_clr = 0;
  endtask

  task automatic test_reset_hold();
    mode = 2'b00; hold_len = 8'd10; orp = 1; dataa_in = 16'h9000;
    tick();
    orp = 0;
    for (int i = 0; i < 3; i++) tick();
    n_vec++; if (ovr_flag !== 1'b1 || dataa_out !== 16'h8000) begin n_err++; $display("FAIL hold_before_rst: got %b/%h expected 1/8000", ovr_flag, dataa_out); end
    #2 rst = 0;
    #1;
    model_reset();
    n_vec++; if (dataa_out !== '0 || ovr_flag !== 1'b0 || ovr_cnt !== '0) begin n_err++; $display("FAIL rst_hold: got %h/%b/%h expected 0", dataa_out, ovr_flag, ovr_cnt); end
    n_vec++; if (datab_out !== '0 || datac_out !== '0) begin n_err++; $display("FAIL rst_hold_nco: got %h/%h expected 0", datab_out, datac_out); end
    @(negedge clk); rst = 1; dataa_in = 16'h0042;
    tick();
    n_vec++; if (ovr_flag !== 1'b0 || dataa_out !== 16'h0042 || dataa_out !== exp_a) begin n_err++; $display("FAIL post_rst: got %b/%h expected 0/0042", ovr_flag, dataa_out); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_passthrough();
    test_saturation(16'hF000, 16'h8000);
    test_saturation(16'h0F00, 16'h7fff);
    test_repulse();
    test_ramp();
    test_nco();
    test_cnt_sat();
    test_random();
    test_reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
